instr_decode_queue: RTL and testbench
=====================================

// Module: instr_decode_queue
// PURPOSE
//  Instruction queue + field decoder between fetch and decode/control of the MIPS CPU.
//  Buffers up to DEPTH fetched instructions with their PCs on a valid/ready handshake.
//  Splits the head entry into opcode/rs/rt/rd/shamt/funct/immediate/jump fields and an extended immediate.
//  Flush support for branch/jump redirect. Fetch and decode can stall independently.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >=2
//  PCW    32  PC width carried alongside each instruction
// PORTS
//  CLK        in   1         clock; all state updates on posedge
//  RST        in   1         asynchronous, active-low reset
//  in_valid   in   1         fetch presents in_instr/in_pc
//  in_ready   out  1         queue can accept this cycle
//  in_instr   in   32        fetched instruction word
//  in_pc      in   PCW       PC of in_instr
//  flush      in   1         discard all queued entries (redirect)
//  out_valid  out  1         head entry valid
//  out_ready  in   1         decode consumes head this cycle
//  out_pc     out  PCW       PC of head entry
//  Opcode     out  6         head[31:26]
//  rs         out  5         head[25:21]
//  rt         out  5         head[20:16]
//  rd         out  5         head[15:11]
//  shamt      out  5         head[10:6]
//  funct      out  6         head[5:0]
//  immediate  out  16        head[15:0]
//  imm_ext    out  32        extended immediate (see CONFIGURATION)
//  jaddr      out  26        head[25:0]
//  count      out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset (RST=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0; storage need not be cleared.
//  - in_ready = (count<DEPTH) && !flush. out_valid = (count!=0).
//  - push = in_valid&&in_ready: write {in_pc,in_instr} at wr_ptr, wr_ptr+1 mod DEPTH.
//  - pop  = out_valid&&out_ready: rd_ptr+1 mod DEPTH.
//  - count += push - pop; push and pop in the same cycle leave count unchanged.
//  - Full: in_ready=0 even if a pop occurs that cycle (no pass-through); refill next cycle.
//  - Empty: out_valid=0, no pop; a pushed word appears on outputs 1 cycle after its push edge (latency 1).
//  - Pointers wrap naturally (DEPTH power of two); no bypass path from in_* to out_*.
//  - flush=1: at the next edge ptrs and count clear to 0; a concurrent pop is discarded.
//    in_ready=0 that cycle, so no push is taken.
//  - All decoded outputs and out_pc are combinational from the head entry.
//    They are forced to 0 when out_valid=0 (including after reset).
//  - Head fields stay stable while out_valid && !out_ready (stall holds output).
//  - RST asserted mid-operation: queue empties immediately, outputs go to 0 asynchronously.
// CONFIGURATION
//  Macro DECODE_ZERO_EXT_EN:
//   defined -> imm_ext = {16'h0,immediate} for Opcode 6'h0C (andi), 6'h0D (ori), 6'h0E (xori);
//              sign-extended for all other opcodes.
//   undefined -> imm_ext = {{16{immediate[15]}},immediate} for every opcode.
// STRUCTURE
//  - Package cpu_decode_pkg: field widths/bit positions, OP_ANDI/OP_ORI/OP_XORI constants,
//    and an instr_fields_t typedef.
//  - Sub-module instr_field_split: combinational 32-bit word -> fields + imm_ext, with the
//    macro handled inside; the queue instantiates it once on the head entry.
//  - Storage: flat register array DEPTH x (PCW+32); no RAM macro.
// TESTING
//  1 Reset: RST=0 mid-traffic -> count=0, out_valid=0, Opcode/rs/.../imm_ext/out_pc=0.
//  2 Single word: push 0x2128FFFC @pc 0x400, out_ready=1 -> next cycle out_valid=1,
//    Opcode=0x08, rs=9, rt=8, immediate=0xFFFC, imm_ext=0xFFFFFFFC; count back to 0 after pop.
//  3 Fill: DEPTH=4, out_ready=0, 5 pushes offered -> 4 accepted, in_ready=0, count=4,
//    head = first word.
//    Then push+pop same cycle while full -> pop only, count=3.
//  4 Wrap: 10 words streamed with random out_ready -> in-order delivery, PCs match, no loss or dupes.
//  5 Flush: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, pushed word dropped.
//  6 Extension: head 0x3508FFFF (ori). With DECODE_ZERO_EXT_EN -> imm_ext=0x0000FFFF;
//    without it -> 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: MIPS instruction field layout and the decoded-field record.
package cpu_decode_pkg;
    localparam int INSTR_W = 32;
    localparam int OP_LSB = 26, OP_W = 6;
    localparam int RS_LSB = 21, RT_LSB = 16, RD_LSB = 11, SH_LSB = 6, REG_W = 5;
    localparam int FN_W = 6, IMM_W = 16, JADDR_W = 26;
    localparam logic [OP_W-1:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
    typedef struct packed {
        logic [OP_W-1:0]    opcode;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   shamt;
        logic [FN_W-1:0]    funct;
        logic [IMM_W-1:0]   immediate;
        logic [INSTR_W-1:0] imm_ext;
        logic [JADDR_W-1:0] jaddr;
    } instr_fields_t;
    function automatic logic is_logic_imm(input logic [OP_W-1:0] op);
        return op == OP_ANDI || op == OP_ORI || op == OP_XORI;
    endfunction
endpackage

// File: rtl/instr_decode_queue_if.sv
// instr_decode_queue_if: fetch-side push channel, decode-side head channel and decoded fields.
interface instr_decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int PCW   = 32
);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_instr;
    logic [PCW-1:0]               in_pc;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [PCW-1:0]               out_pc;
    logic [5:0]                   Opcode;
    logic [4:0]                   rs;
    logic [4:0]                   rt;
    logic [4:0]                   rd;
    logic [4:0]                   shamt;
    logic [5:0]                   funct;
    logic [15:0]                  immediate;
    logic [31:0]                  imm_ext;
    logic [25:0]                  jaddr;
    logic [$clog2(DEPTH+1)-1:0]   count;
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, Opcode, rs, rt, rd, shamt, funct,
               immediate, imm_ext, jaddr, count
    );
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, Opcode, rs, rt, rd, shamt, funct,
               immediate, imm_ext, jaddr, count
    );
endinterface

// File: rtl/instr_field_split.sv
// instr_field_split: combinational MIPS word -> fields + extended immediate.
// DECODE_ZERO_EXT_EN selects zero extension for andi/ori/xori.
module instr_field_split
    import cpu_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output instr_fields_t      fields_o
);
    logic [IMM_W-1:0]   imm;
    logic [INSTR_W-1:0] sext;
    assign imm  = instr_i[IMM_W-1:0];
    assign sext = {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
    always_comb begin
        fields_o.opcode    = instr_i[OP_LSB +: OP_W];
        fields_o.rs        = instr_i[RS_LSB +: REG_W];
        fields_o.rt        = instr_i[RT_LSB +: REG_W];
        fields_o.rd        = instr_i[RD_LSB +: REG_W];
        fields_o.shamt     = instr_i[SH_LSB +: REG_W];
        fields_o.funct     = instr_i[FN_W-1:0];
        fields_o.immediate = imm;
`ifdef DECODE_ZERO_EXT_EN
        fields_o.imm_ext   = is_logic_imm(instr_i[OP_LSB +: OP_W]) ? {{(INSTR_W-IMM_W){1'b0}}, imm} : sext;
`else
        fields_o.imm_ext   = sext;
`endif
        fields_o.jaddr     = instr_i[JADDR_W-1:0];
    end
endmodule

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: DEPTH-entry instruction/PC FIFO between fetch and decode with head field split.
// Optional DECODE_ZERO_EXT_EN (handled in instr_field_split) zero-extends logical immediates.
module instr_decode_queue
    import cpu_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    instr_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PCW + INSTR_W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid, push, pop;
    logic [EW-1:0] head;
    instr_fields_t f;

    // Full blocks push even when a pop happens this cycle: no pass-through.
    assign valid        = count_q != '0;
    assign bus.in_ready = (count_q < CW'(DEPTH)) && !bus.flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_pc, bus.in_instr};
    end

    // Masking the head word to zero makes every decoded field zero when empty.
    assign head = valid ? mem_q[rd_ptr_q] : '0;

    instr_field_split u_split (
        .instr_i  (head[INSTR_W-1:0]),
        .fields_o (f)
    );

    assign bus.out_valid = valid;
    assign bus.count     = count_q;
    assign bus.out_pc    = head[EW-1:INSTR_W];
    assign bus.Opcode    = f.opcode;
    assign bus.rs        = f.rs;
    assign bus.rt        = f.rt;
    assign bus.rd        = f.rd;
    assign bus.shamt     = f.shamt;
    assign bus.funct     = f.funct;
    assign bus.immediate = f.immediate;
    assign bus.imm_ext   = f.imm_ext;
    assign bus.jaddr     = f.jaddr;
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed stimulus with an expected-word scoreboard and a pop monitor.
module tb_instr_decode_queue;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    logic [63:0] exp_q[$];

    instr_decode_queue_if #(.DEPTH(4), .PCW(32)) bus ();
    instr_decode_queue #(.DEPTH(4), .PCW(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w);
`ifdef DECODE_ZERO_EXT_EN
        if (w[31:26] inside {6'h0C, 6'h0D, 6'h0E}) return {16'h0, w[15:0]};
`endif
        return {{16{w[15]}}, w[15:0]};
    endfunction

    // Drive one cycle, then check handshake/count against the bench model and record accepted words.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic acc);
        logic pm;
        @(posedge CLK);
        #1;
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = rdy; bus.flush = fl;
        @(negedge CLK);
        #1;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, m_cnt < 4 && !fl});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_cnt != 0});
        chk("count", 64'(bus.count), 64'(m_cnt));
        acc = v && m_cnt < 4 && !fl;
        pm  = m_cnt != 0 && rdy;
        if (fl) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (acc) exp_q.push_back({pc, ins});
            m_cnt = m_cnt + int'(acc) - int'(pm);
        end
    endtask

    initial begin : monitor
        logic [63:0] w;
        forever begin
            @(negedge CLK);
            if (RST && bus.out_valid && bus.out_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 64'(bus.out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_pc", 64'(bus.out_pc), 64'(w[63:32]));
                    chk("sb_op", 64'(bus.Opcode), 64'(w[31:26]));
                    chk("sb_rs", 64'(bus.rs), 64'(w[25:21]));
                    chk("sb_rt", 64'(bus.rt), 64'(w[20:16]));
                    chk("sb_rd", 64'(bus.rd), 64'(w[15:11]));
                    chk("sb_shamt", 64'(bus.shamt), 64'(w[10:6]));
                    chk("sb_funct", 64'(bus.funct), 64'(w[5:0]));
                    chk("sb_imm", 64'(bus.immediate), 64'(w[15:0]));
                    chk("sb_ext", 64'(bus.imm_ext), 64'(ext(w[31:0])));
                    chk("sb_jaddr", 64'(bus.jaddr), 64'(w[25:0]));
                end
            end
        end
    end

    initial begin : stim
        logic a;
        int   i, cyc;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0; bus.flush = 0;
        #2;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ext", 64'(bus.imm_ext), 64'd0);
        @(posedge CLK); #1 RST = 1'b1;

        // single word through the queue
        step(1, 32'h2128FFFC, 32'h400, 1, 0, a);
        step(0, 0, 0, 1, 0, a);
        chk("t2_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_op", 64'(bus.Opcode), 64'h08);
        chk("t2_rs", 64'(bus.rs), 64'd9);
        chk("t2_rt", 64'(bus.rt), 64'd8);
        chk("t2_imm", 64'(bus.immediate), 64'hFFFC);
        chk("t2_ext", 64'(bus.imm_ext), 64'hFFFF_FFFC);
        chk("t2_pc", 64'(bus.out_pc), 64'h400);
        step(0, 0, 0, 0, 0, a);
        chk("t2_count0", 64'(bus.count), 64'd0);

        // fill past capacity, then push+pop while full
        step(1, 32'h8D280004, 32'h100, 0, 0, a);
        step(1, 32'h01095020, 32'h104, 0, 0, a);
        step(1, 32'h3C01ABCD, 32'h108, 0, 0, a);
        step(1, 32'h08000040, 32'h10C, 0, 0, a);
        step(1, 32'hAD2A0008, 32'h110, 0, 0, a);
        chk("t3_accept5", 64'(a), 64'd0);
        chk("t3_count", 64'(bus.count), 64'd4);
        chk("t3_ready", 64'(bus.in_ready), 64'd0);
        chk("t3_head_pc", 64'(bus.out_pc), 64'h100);
        chk("t3_head_rt", 64'(bus.rt), 64'd8);
        chk("t3_head_ext", 64'(bus.imm_ext), 64'h4);
        step(1, 32'h11090003, 32'h114, 1, 0, a);
        step(0, 0, 0, 0, 0, a);
        chk("t3_count3", 64'(bus.count), 64'd3);
        chk("t3_head2_pc", 64'(bus.out_pc), 64'h104);
        chk("t3_head2_funct", 64'(bus.funct), 64'h20);

        // flush with a concurrent push offered
        step(1, 32'h21080001, 32'h200, 1, 1, a);
        step(0, 0, 0, 0, 0, a);
        chk("t5_count", 64'(bus.count), 64'd0);
        chk("t5_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_pc", 64'(bus.out_pc), 64'd0);

        // ori immediate extension
        step(1, 32'h3508FFFF, 32'h300, 0, 0, a);
        step(0, 0, 0, 0, 0, a);
        chk("t6_op", 64'(bus.Opcode), 64'h0D);
        chk("t6_imm", 64'(bus.immediate), 64'hFFFF);
`ifdef DECODE_ZERO_EXT_EN
        chk("t6_ext", 64'(bus.imm_ext), 64'h0000_FFFF);
`else
        chk("t6_ext", 64'(bus.imm_ext), 64'hFFFF_FFFF);
`endif
        step(0, 0, 0, 1, 0, a);

        // streaming with random back-pressure across pointer wrap
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 200) begin
            step(1, 32'h2000_0000 | (i << 16) | (i * 32'h1357), 32'h1000 + 4 * i,
                 1'($urandom_range(0, 1)), 0, a);
            if (a) i++;
            cyc++;
        end
        chk("t4_sent", 64'(i), 64'd10);
        cyc = 0;
        while (m_cnt != 0 && cyc < 20) begin
            step(0, 0, 0, 1, 0, a);
            cyc++;
        end
        step(0, 0, 0, 0, 0, a);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // asynchronous reset mid-traffic
        step(1, 32'h8D280004, 32'h500, 0, 0, a);
        step(1, 32'h3C01ABCD, 32'h504, 0, 0, a);
        step(0, 0, 0, 0, 0, a);
        #2 RST = 1'b0;
        #1;
        chk("t1_count", 64'(bus.count), 64'd0);
        chk("t1_valid", 64'(bus.out_valid), 64'd0);
        chk("t1_op", 64'(bus.Opcode), 64'd0);
        chk("t1_rt", 64'(bus.rt), 64'd0);
        chk("t1_imm", 64'(bus.immediate), 64'd0);
        chk("t1_ext", 64'(bus.imm_ext), 64'd0);
        chk("t1_jaddr", 64'(bus.jaddr), 64'd0);
        chk("t1_pc", 64'(bus.out_pc), 64'd0);
        exp_q.delete();
        m_cnt = 0;
        @(posedge CLK); #1 RST = 1'b1;
        step(1, 32'h01095020, 32'h600, 1, 0, a);
        step(0, 0, 0, 1, 0, a);
        step(0, 0, 0, 0, 0, a);
        chk("t1_after_count", 64'(bus.count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
